// File: rtl/ip2_scan_chain_reader_if.sv
// ----------------------------------------------------------------------------
// ip2_scan_chain_reader_if
// Word read bus of the IP2 scan-chain reader.
//   rd_en    : read request (one cycle)
//   rd_addr  : word address
//   rd_data  : read data, returned the cycle after rd_en, held until next read
//   rd_valid : one-cycle pulse qualifying rd_data
// Modports: master = requester (AXI read path), slave = reader block.
// ----------------------------------------------------------------------------
interface ip2_scan_chain_reader_if #(
    parameter int AW     = 5,
    parameter int WORD_W = 32
);
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/ip2_scan_chain_reader.sv
// ----------------------------------------------------------------------------
// ip2_scan_chain_reader
// Receive end of the IP2 scan chain. After a start pulse, scan_out is sampled
// once per bx_strobe, sample_dly+1 clocks after the strobe, and the bits are
// packed LSB-first into NWORDS words of WORD_W bits, readable by word address.
//
// Ports
//   fw_pl_clk1  : clock
//   fw_rst      : synchronous active-high reset (clears storage as well)
//   start/abort : one-cycle control pulses (abort has priority)
//   bx_strobe   : one pulse per bxclk period
//   sample_dly  : clocks from strobe to sample (0 = sample next clock)
//   scan_out    : serial chain data
//   rd_bus      : word read port (slave side of ip2_scan_chain_reader_if)
//   busy        : capture in progress
//   done        : sticky, full chain captured
//   overrun     : sticky, strobe seen while still waiting out sample_dly
//   bit_cnt     : bits captured so far
//   scan_parity : (only with SCAN_READER_PARITY_EN) XOR of captured bits
//
// Optional feature: define SCAN_READER_PARITY_EN to add scan_parity and make
// word address NWORDS return {0, scan_parity}. Without it that address reads
// 0 like every other out-of-range address.
// ----------------------------------------------------------------------------
module ip2_scan_chain_reader #(
    parameter int SCAN_BITS = 768,
    parameter int WORD_W    = 32,
    parameter int NWORDS    = SCAN_BITS / WORD_W,
    parameter int DLY_W     = 6,
    parameter int CW        = $clog2(SCAN_BITS + 1)
) (
    input  logic                fw_pl_clk1,
    input  logic                fw_rst,
    input  logic                start,
    input  logic                abort,
    input  logic                bx_strobe,
    input  logic [DLY_W-1:0]    sample_dly,
    input  logic                scan_out,
    ip2_scan_chain_reader_if.slave rd_bus,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [CW-1:0]       bit_cnt
`ifdef SCAN_READER_PARITY_EN
    ,
    output logic                scan_parity
`endif
);
    localparam int AW = $clog2(NWORDS);
    localparam int BW = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STB,
        DELAY,
        SAMPLE,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [DLY_W-1:0]   dly_cnt_reg, dly_cnt_next;
    logic [CW-1:0]      bit_cnt_reg;
    logic               busy_reg, done_reg, overrun_reg;
    logic               clear_run, sample_en, finish, set_overrun;
    logic [AW-1:0]      word_idx;
    logic [BW-1:0]      bit_idx;
    logic [WORD_W-1:0]  mem_rd [NWORDS];
    logic [WORD_W-1:0]  rd_data_reg;
    logic               rd_valid_reg;
`ifdef SCAN_READER_PARITY_EN
    logic               parity_reg;
`endif

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            state_reg   <= IDLE;
            dly_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            dly_cnt_reg <= dly_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dly_cnt_next = dly_cnt_reg;
        clear_run    = 1'b0;
        sample_en    = 1'b0;
        finish       = 1'b0;
        set_overrun  = 1'b0;
        if (abort) begin
            // Abort beats everything, including a same-cycle start or sample.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A strobe coincident with start is seen here and dropped.
                    if (start) begin
                        state_next = WAIT_STB;
                        clear_run  = 1'b1;
                    end
                end
                WAIT_STB: begin
                    if (bx_strobe) begin
                        if (sample_dly == '0) begin
                            state_next = SAMPLE;
                        end else begin
                            state_next   = DELAY;
                            dly_cnt_next = sample_dly;
                        end
                    end
                end
                DELAY: begin
                    if (bx_strobe) begin
                        set_overrun = 1'b1;
                    end
                    if (dly_cnt_reg <= DLY_W'(1)) begin
                        state_next = SAMPLE;
                    end else begin
                        dly_cnt_next = dly_cnt_reg - DLY_W'(1);
                    end
                end
                SAMPLE: begin
                    sample_en  = 1'b1;
                    state_next = (bit_cnt_reg == CW'(SCAN_BITS - 1)) ? DONE : WAIT_STB;
                end
                DONE: begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status registers
    // ------------------------------------------------------------------
    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (abort) begin
            busy_reg    <= 1'b0;
        end else begin
            if (clear_run) begin
                bit_cnt_reg <= '0;
                busy_reg    <= 1'b1;
                done_reg    <= 1'b0;
                overrun_reg <= 1'b0;
            end
            if (set_overrun) begin
                overrun_reg <= 1'b1;
            end
            if (sample_en) begin
                bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
            if (finish) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

`ifdef SCAN_READER_PARITY_EN
    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            parity_reg <= 1'b0;
        end else if (clear_run) begin
            parity_reg <= 1'b0;
        end else if (sample_en) begin
            parity_reg <= parity_reg ^ scan_out;
        end
    end
    assign scan_parity = parity_reg;
`endif

    // ------------------------------------------------------------------
    // Capture storage: one register word per generate slice, bit-addressed
    // write of the current bit. Storage is never cleared by start; a full
    // capture overwrites every bit.
    // ------------------------------------------------------------------
    assign word_idx = AW'(bit_cnt_reg >> BW);
    assign bit_idx  = bit_cnt_reg[BW-1:0];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            logic [WORD_W-1:0] word_reg;
            always_ff @(posedge fw_pl_clk1) begin
                if (fw_rst) begin
                    word_reg <= '0;
                end else if (sample_en && (word_idx == AW'(gi))) begin
                    word_reg[bit_idx] <= scan_out;
                end
            end
            assign mem_rd[gi] = word_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered read port. It reads the pre-edge contents, so a read that
    // hits the word being written in the same cycle gets the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_bus.rd_en;
            if (rd_bus.rd_en) begin
                if (rd_bus.rd_addr < AW'(NWORDS)) begin
                    rd_data_reg <= mem_rd[rd_bus.rd_addr];
`ifdef SCAN_READER_PARITY_EN
                end else if (rd_bus.rd_addr == AW'(NWORDS)) begin
                    rd_data_reg <= {{(WORD_W-1){1'b0}}, parity_reg};
`endif
                end else begin
                    rd_data_reg <= '0;
                end
            end
        end
    end

    assign rd_bus.rd_data  = rd_data_reg;
    assign rd_bus.rd_valid = rd_valid_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign overrun         = overrun_reg;
    assign bit_cnt         = bit_cnt_reg;

endmodule

// File: tb/tb_ip2_scan_chain_reader.sv
module tb_ip2_scan_chain_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bx_strobe = 1'b0;
    logic       scan_out = 1'b0;
    logic [5:0] sample_dly = '0;
    logic       busy, done, overrun;
    logic [9:0] bit_cnt;
`ifdef SCAN_READER_PARITY_EN
    logic       scan_parity;
`endif

    ip2_scan_chain_reader_if #(.AW(5), .WORD_W(32)) rd_bus ();

    ip2_scan_chain_reader dut (
        .fw_pl_clk1 (clk),
        .fw_rst     (rst),
        .start      (start),
        .abort      (abort),
        .bx_strobe  (bx_strobe),
        .sample_dly (sample_dly),
        .scan_out   (scan_out),
        .rd_bus     (rd_bus),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .bit_cnt    (bit_cnt)
`ifdef SCAN_READER_PARITY_EN
        ,
        .scan_parity(scan_parity)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [767:0] pat, pat2, pat3, pat4;
    logic [31:0]  w0_exp, par_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor: every rd_valid pops one expected word.
    always @(negedge clk) begin
        if (!rst && rd_bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid with data %h, expected no read", rd_bus.rd_data);
            end else begin
                chk("rd_data", rd_bus.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        rd_bus.rd_addr = a;
        rd_bus.rd_en   = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_bus.rd_en   = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drv(input logic stb, input logic so);
        bx_strobe = stb;
        scan_out  = so;
        tick();
        bx_strobe = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int period);
        drv(1'b1, b);
        repeat (period - 1) drv(1'b0, b);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && done !== 1'b1; i++) tick();
        chk("done_set", {31'b0, done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion before 1 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rd_bus.rd_en   = 1'b0;
        rd_bus.rd_addr = '0;
        for (int i = 0; i < 24; i++) begin
            pat [i*32 +: 32] = {8'hA5, 8'(i), 8'h5A, ~8'(i)};
            pat2[i*32 +: 32] = {8'h3C, 8'(i * 7), 8'hC3, 8'(i)};
        end
        pat3 = ~pat2;
        pat4 = '0;
        pat4[5] = 1'b1;
        pat4[300] = 1'b1;
        pat4[767] = 1'b1;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_bit_cnt", {22'b0, bit_cnt}, 32'd0);
        chk("rst_rd_valid", {31'b0, rd_bus.rd_valid}, 32'd0);
        rd(5'd0, 32'h0);
        rd(5'd23, 32'h0);

        // T1: full capture; strobe coincident with start must be ignored,
        // and a start pulse mid-capture must be ignored.
        sample_dly = 6'd2;
        start = 1'b1; bx_strobe = 1'b1; scan_out = ~pat[0];
        tick();
        start = 1'b0; bx_strobe = 1'b0;
        tick();
        chk("t1_busy", {31'b0, busy}, 32'd1);
        for (int k = 0; k < 768; k++) begin
            if (k == 400) start = 1'b1;
            drv(1'b1, pat[k]);
            start = 1'b0;
            repeat (7) drv(1'b0, pat[k]);
        end
        wait_done();
        chk("t1_bit_cnt", {22'b0, bit_cnt}, 32'd768);
        chk("t1_busy_end", {31'b0, busy}, 32'd0);
        for (int w = 0; w < 24; w++) rd(5'(w), pat[w*32 +: 32]);
        rd(5'd30, 32'h0);
`ifdef SCAN_READER_PARITY_EN
        par_exp = {31'b0, ^pat};
        chk("t1_parity", {31'b0, scan_parity}, par_exp);
`else
        par_exp = 32'h0;
`endif
        rd(5'd24, par_exp);

        // T2: sample timing. dly=5 samples strobe+6, dly=0 samples strobe+1.
        sample_dly = 6'd5;
        do_start();
        drv(1'b1, 1'b0); repeat (5) drv(1'b0, 1'b0); repeat (4) drv(1'b0, 1'b1);
        drv(1'b1, 1'b1); repeat (5) drv(1'b0, 1'b1); repeat (4) drv(1'b0, 1'b0);
        sample_dly = 6'd0;
        drv(1'b1, 1'b0); drv(1'b0, 1'b1); repeat (3) drv(1'b0, 1'b0);
        drv(1'b1, 1'b1); drv(1'b0, 1'b0); repeat (3) drv(1'b0, 1'b1);
        chk("t2_bit_cnt", {22'b0, bit_cnt}, 32'd4);
        w0_exp = {pat[31:4], 4'b0101};
        rd(5'd0, w0_exp);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t2_abort_busy", {31'b0, busy}, 32'd0);

        // T3: overrun. dly=10, strobe every 4 -> one bit per 12 cycles,
        // 40 strobes -> 14 bits.
        sample_dly = 6'd10;
        do_start();
        for (int k = 0; k < 40; k++) send_bit(1'b1, 4);
        repeat (15) tick();
        chk("t3_overrun", {31'b0, overrun}, 32'd1);
        chk("t3_bit_cnt", {22'b0, bit_cnt}, 32'd14);
        chk("t3_busy", {31'b0, busy}, 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // T4: abort at 100 bits, abort+start same cycle, then full restart
        // with a partial-word read mid capture (T5).
        sample_dly = 6'd2;
        do_start();
        chk("t4_overrun_clr", {31'b0, overrun}, 32'd0);
        for (int k = 0; k < 100; k++) send_bit(pat3[k], 8);
        chk("t4_bit_cnt100", {22'b0, bit_cnt}, 32'd100);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_abort_busy", {31'b0, busy}, 32'd0);
        chk("t4_abort_done", {31'b0, done}, 32'd0);
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("t4_abort_wins", {31'b0, busy}, 32'd0);
        do_start();
        for (int k = 0; k < 40; k++) send_bit(pat2[k], 8);
        rd(5'd1, {pat3[63:40], pat2[39:32]});
        for (int k = 40; k < 768; k++) send_bit(pat2[k], 8);
        wait_done();
        chk("t4_bit_cnt", {22'b0, bit_cnt}, 32'd768);
        for (int w = 0; w < 24; w++) rd(5'(w), pat2[w*32 +: 32]);

        // T6: three ones, fast strobes with dly=0.
        sample_dly = 6'd0;
        do_start();
        for (int k = 0; k < 768; k++) send_bit(pat4[k], 2);
        wait_done();
        rd(5'd23, 32'h8000_0000);
        rd(5'd9, 32'h0000_1000);
        rd(5'd0, 32'h0000_0020);
`ifdef SCAN_READER_PARITY_EN
        chk("t6_parity", {31'b0, scan_parity}, 32'd1);
        rd(5'd24, 32'h1);
`else
        rd(5'd24, 32'h0);
`endif

        repeat (3) tick();
        chk("rd_pending", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
